// File: rtl/ex_pkg.sv
// ex_pkg: opcodes and ID/EX register layout shared by the execute stage
package ex_pkg;
  localparam logic [4:0] OP_BEQ  = 5'h10;
  localparam logic [4:0] OP_BNE  = 5'h11;
  localparam logic [4:0] OP_CALL = 5'h12;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  op;
    logic        a_sel;
    logic        b_sel;
    logic        ret;
    logic [31:0] qa;
    logic [31:0] qb;
  } ex_reg_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/ex_branch_resolve_ras.sv
// ras_stack: return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_pop;
  always_comb begin
    do_pop = pop && !empty;
    ptr_d  = push ? ptr_q + 1'b1 : do_pop ? ptr_q - 1'b1 : ptr_q;
    cnt_d  = push ? (cnt_q == FULL ? cnt_q : cnt_q + 1'b1) : do_pop ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end
  assign top   = mem_q[ptr_q - 1'b1];
  assign empty = cnt_q == '0;
endmodule

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: ID/EX register, branch/call/return resolution and fetch redirect
module ex_branch_resolve
  import ex_pkg::*;
#(
  parameter int          RAS_DEPTH     = 8,
  parameter int          BRANCH_SHADOW = 2,
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_VALID,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] IF_PC,
  input  logic [4:0]  ALU_OP,
  input  logic        A_SEL,
  input  logic        B_SEL,
  input  logic        ret_enable,
  input  logic [31:0] QT_A,
  input  logic [31:0] QT_B,
  output logic        ALU_Z,
  output logic        BRANCH,
  output logic [31:0] SE_B,
  output logic [31:0] SE_PC,
  output logic        EX_VALID,
  output logic        RAS_ERR
);
  localparam int SW = $clog2(BRANCH_SHADOW + 2);
  localparam logic [SW-1:0] SHADOW = SW'(BRANCH_SHADOW);
  ex_reg_t       ex_q, ex_d;
  logic          ex_valid_q, ex_valid_d;
  logic [SW-1:0] squash_q, squash_d;
  logic          alu_z_q, alu_z_d;
  logic          branch_q, branch_d;
  logic [31:0]   se_pc_q, se_pc_d;
  logic          ras_err_q, ras_err_d;
  logic [31:0]   se_b, op_a, op_b, target, ras_top;
  logic          z, is_call, taken, push, pop, capture, ras_empty;
  logic          unused_hi;
  always_comb begin
    se_b    = sext16(ex_q.instr[15:0]);
    op_a    = ex_q.a_sel ? ex_q.qa : ex_q.pc;
    op_b    = ex_q.b_sel ? se_b : ex_q.qb;
    z       = (op_a - op_b) == '0;
    is_call = ex_q.op == OP_CALL;
    taken   = ex_valid_q && (ex_q.ret || is_call || (ex_q.op == OP_BEQ && z) || (ex_q.op == OP_BNE && !z));
    target  = ex_q.ret ? (ras_empty ? RESET_VECTOR : ras_top) :
              is_call  ? {ex_q.pc[31:26], ex_q.instr[25:0]} : ex_q.pc + 32'd1 + se_b;
    push    = ex_valid_q && !ex_q.ret && is_call;
    pop     = ex_valid_q && ex_q.ret;
    // the slot arriving on the redirect edge is the first wrong-path one
    capture    = IF_VALID && squash_q == '0 && !taken;
    ex_d       = capture ? ex_reg_t'{instr: INSTRUCTION, pc: IF_PC, op: ALU_OP, a_sel: A_SEL,
                                     b_sel: B_SEL, ret: ret_enable, qa: QT_A, qb: QT_B} : ex_q;
    ex_valid_d = capture;
    squash_d   = taken ? SHADOW - SW'(IF_VALID) : (IF_VALID && squash_q != '0) ? squash_q - 1'b1 : squash_q;
    alu_z_d    = ex_valid_q ? z : alu_z_q;
    branch_d   = taken;
    se_pc_d    = taken ? target : se_pc_q;
    ras_err_d  = ras_err_q || (pop && ras_empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      squash_q   <= '0;
      alu_z_q    <= 1'b0;
      branch_q   <= 1'b0;
      se_pc_q    <= '0;
      ras_err_q  <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      squash_q   <= squash_d;
      alu_z_q    <= alu_z_d;
      branch_q   <= branch_d;
      se_pc_q    <= se_pc_d;
      ras_err_q  <= ras_err_d;
    end
  end
  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(ex_q.pc + 32'd1),
    .top      (ras_top),
    .empty    (ras_empty)
  );
  assign unused_hi = ^ex_q.instr[31:26];
  assign ALU_Z     = alu_z_q;
  assign BRANCH    = branch_q;
  assign SE_B      = se_b;
  assign SE_PC     = se_pc_q;
  assign EX_VALID  = ex_valid_q;
  assign RAS_ERR   = ras_err_q;
endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb_ex_branch_resolve: directed vectors with a scoreboard checked by an independent monitor
module tb_ex_branch_resolve;
  import ex_pkg::*;
  logic clk = 0, rst = 1;
  logic if_valid = 0, a_sel = 0, b_sel = 0, ret_en = 0;
  logic [31:0] instruction = 0, if_pc = 0, qt_a = 0, qt_b = 0;
  logic [4:0] alu_op = 0;
  logic alu_z, branch, ex_valid, ras_err;
  logic [31:0] se_b, se_pc;
  typedef struct {
    logic [31:0] se_b;
    logic        br;
    logic        z;
    logic [31:0] tgt;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic pend = 0;
  int total = 0, bad = 0;

  ex_branch_resolve #(.RAS_DEPTH(8), .BRANCH_SHADOW(2), .RESET_VECTOR(32'h0000_0400)) dut (
    .clk(clk), .rst(rst), .IF_VALID(if_valid), .INSTRUCTION(instruction), .IF_PC(if_pc),
    .ALU_OP(alu_op), .A_SEL(a_sel), .B_SEL(b_sel), .ret_enable(ret_en), .QT_A(qt_a), .QT_B(qt_b),
    .ALU_Z(alu_z), .BRANCH(branch), .SE_B(se_b), .SE_PC(se_pc), .EX_VALID(ex_valid), .RAS_ERR(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic slot(input logic v, input logic [31:0] ins, pc, input logic [4:0] op,
                      input logic asl, bsl, rt, input logic [31:0] a, b);
    @(negedge clk);
    #1;
    if_valid = v; instruction = ins; if_pc = pc; alu_op = op;
    a_sel = asl; b_sel = bsl; ret_en = rt; qt_a = a; qt_b = b;
  endtask

  task automatic live(input logic [31:0] ins, pc, input logic [4:0] op, input logic asl, bsl, rt,
                      input logic [31:0] a, b, e_seb, input logic br, z,
                      input logic [31:0] tgt, input logic err);
    exp_t e;
    e.se_b = e_seb; e.br = br; e.z = z; e.tgt = tgt; e.err = err;
    sb.push_back(e);
    slot(1'b1, ins, pc, op, asl, bsl, rt, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) slot(1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // wrong-path filler: a return that would pop or flag if it were ever captured
  task automatic junk(input int n);
    repeat (n) slot(1'b1, 32'h0000_0777, 32'h99, OP_CALL, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else begin
        if (pend) begin
          chk("branch", branch, cur.br);
          chk("alu_z", alu_z, cur.z);
          chk("se_pc", se_pc, cur.tgt);
          chk("ras_err", ras_err, cur.err);
        end else chk("branch_idle", branch, 1'b0);
        pend = ex_valid;
        if (ex_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            pend = 0;
            $display("FAIL live: got unexpected live instruction want none at %0t", $time);
          end else begin
            cur = sb.pop_front();
            chk("se_b", se_b, cur.se_b);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_alu_z", alu_z, 0);
      chk("rst_branch", branch, 0);
      chk("rst_se_b", se_b, 0);
      chk("rst_se_pc", se_pc, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ras_err", ras_err, 0);
    end
    // taken BEQ: 0x10 + 1 - 4 = 0x0D, then two squashed slots
    live(32'h0000_FFFC, 32'h10, OP_BEQ, 1, 0, 0, 5, 5, 32'hFFFF_FFFC, 1, 1, 32'h0D, 0);
    junk(2);
    live(32'h0000_0005, 32'h14, 5'h00, 1, 0, 0, 3, 7, 32'h5, 0, 0, 32'h0D, 0);
    // BNE with equal operands (pc vs immediate), followed back-to-back
    live(32'h0000_0030, 32'h30, OP_BNE, 0, 1, 0, 32'hAA, 32'hBB, 32'h30, 0, 1, 32'h0D, 0);
    live(32'h0000_8000, 32'h31, 5'h00, 0, 0, 0, 0, 32'h32, 32'hFFFF_8000, 0, 0, 32'h0D, 0);
    // call then return
    live(32'h0000_0100, 32'h20, OP_CALL, 1, 0, 0, 0, 0, 32'h100, 1, 1, 32'h100, 0);
    junk(2);
    live(32'h0, 32'h40, 5'h00, 1, 0, 1, 0, 0, 32'h0, 1, 1, 32'h21, 0);
    junk(2);
    // nine calls into an eight-deep stack
    for (int i = 0; i < 9; i++) begin
      live(32'(32'hFC00_0200 + i), 32'(32'h0400_0000 + 16 * i), OP_CALL, 1, 0, 0, 0, 0,
           32'(32'h200 + i), 1, 1, 32'(32'h0400_0200 + i), 0);
      junk(2);
    end
    for (int k = 8; k >= 1; k--) begin
      live(32'h0, 32'h500, 5'h00, 1, 0, 1, 0, 0, 32'h0, 1, 1, 32'(32'h0400_0001 + 16 * k), 0);
      junk(2);
    end
    live(32'h0, 32'h500, 5'h00, 1, 0, 1, 0, 0, 32'h0, 1, 1, 32'h400, 1);
    junk(2);
    live(32'h0000_0001, 32'h600, 5'h00, 1, 1, 0, 1, 32'h55, 32'h1, 0, 1, 32'h400, 1);
    // returns in a BEQ shadow with invalid gaps must leave the stack alone
    live(32'h0000_0300, 32'h50, OP_CALL, 1, 0, 0, 0, 0, 32'h300, 1, 1, 32'h300, 1);
    junk(2);
    live(32'h0000_0010, 32'h60, OP_BEQ, 1, 0, 0, 1, 1, 32'h10, 1, 1, 32'h71, 1);
    idle(1);
    junk(1);
    idle(2);
    junk(1);
    idle(1);
    live(32'h0, 32'h70, 5'h00, 1, 0, 1, 0, 0, 32'h0, 1, 1, 32'h51, 1);
    junk(2);
    // reset while a taken branch sits in EX
    live(32'h0, 32'h80, OP_BEQ, 1, 0, 0, 2, 2, 32'h0, 1, 1, 32'h81, 1);
    @(negedge clk);
    #1;
    rst = 1;
    if_valid = 0;
    @(negedge clk);
    chk("rst_mid_branch", branch, 0);
    chk("rst_mid_ex_valid", ex_valid, 0);
    chk("rst_mid_ras_err", ras_err, 0);
    chk("rst_mid_se_pc", se_pc, 0);
    chk("rst_mid_alu_z", alu_z, 0);
    #1 rst = 0;
    live(32'h0000_0002, 32'h90, 5'h00, 0, 0, 0, 0, 32'h90, 32'h2, 0, 1, 32'h0, 0);
    idle(4);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- Execute-stage consumer of the instruction-fetch outputs.
- Latches the fetched instruction and its control word into an ID/EX register.
- Resolves conditional branches, calls and returns, and drives the feedback bus back to fetch (ALU_Z, BRANCH, SE_B, SE_PC).
- Holds a return-address stack and squashes wrong-path instructions in the branch shadow.

Parameters:
- RAS_DEPTH, 8: return-address stack entries; power of two, at least 2.
- BRANCH_SHADOW, 2: number of valid fetch slots squashed after a redirect.
- RESET_VECTOR, 32'h0000_0000: redirect target on return-stack underflow.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- IF_VALID, input, 1: fetch slot holds a real instruction.
- INSTRUCTION, input, 32: fetched instruction word.
- IF_PC, input, 32: word address of INSTRUCTION.
- ALU_OP, input, 5: decoded operation from fetch.
- A_SEL, input, 1: 1 = QT_A, 0 = IF_PC as ALU operand A.
- B_SEL, input, 1: 1 = SE_B, 0 = QT_B as ALU operand B.
- ret_enable, input, 1: instruction is a return.
- QT_A, input, 32: register-file read port A.
- QT_B, input, 32: register-file read port B.
- ALU_Z, output, 1: compare result of the resolved instruction is zero.
- BRANCH, output, 1: one-cycle redirect request to fetch.
- SE_B, output, 32: sign-extended immediate of the instruction in EX.
- SE_PC, output, 32: redirect target; valid while BRANCH = 1.
- EX_VALID, output, 1: EX register holds a live, non-squashed instruction.
- RAS_ERR, output, 1: sticky flag, set on return with an empty stack.

Behaviour:
- Reset (rst high at a rising edge): EX register invalid, ALU_Z = 0, BRANCH = 0, SE_B = 0, SE_PC = 0, EX_VALID = 0, RAS_ERR = 0, stack pointer and count = 0, squash counter = 0. Reset mid-operation discards any in-flight branch.
- Capture at edge k: if IF_VALID = 1 and squash counter = 0, latch INSTRUCTION, IF_PC, ALU_OP, A_SEL, B_SEL, ret_enable, QT_A, QT_B and set EX_VALID.
  - If IF_VALID = 1 and squash counter > 0: decrement the counter and capture nothing.
  - If IF_VALID = 0: capture nothing; the counter holds.
- Resolve: combinational from the EX register; results registered at edge k+1. Latency is 1 cycle from capture to BRANCH/ALU_Z.
- SE_B = sign-extension of INSTRUCTION[15:0]; it is valid in the cycle after capture.
- ALU compare: Z = ((A - B) mod 2^32 == 0), with A and B selected by A_SEL and B_SEL. ALU_Z is updated only for live instructions; otherwise it holds.
- OP_BEQ: taken if Z = 1. OP_BNE: taken if Z = 0. Target = IF_PC + 1 + SE_B, wrapping mod 2^32.
- OP_CALL: always taken. Target = {IF_PC[31:26], INSTRUCTION[25:0]}. Push IF_PC + 1.
- ret_enable (any ALU_OP): always taken. Pop the stack to get the target.
  - Stack empty: target = RESET_VECTOR, set RAS_ERR; pointer and count unchanged.
  - ret_enable has priority over ALU_OP decoding.
- Stack overflow: a push when count = RAS_DEPTH overwrites the oldest entry (pointer wraps, count saturates). No error is raised.
- Taken branch at edge k+1: BRANCH = 1 for exactly one cycle, SE_PC = target, squash counter loaded with BRANCH_SHADOW.
  - The instruction captured at edge k+1 is invalidated in the same edge, so it never resolves or touches the stack.
  - Total squashed valid slots = BRANCH_SHADOW, counting that one.
- Non-taken or non-branch: BRANCH = 0; SE_PC holds its previous value.
- Squashed instructions never push, pop, set RAS_ERR or raise BRANCH.

Decomposition:
- Package ex_pkg holds the ALU_OP localparams: OP_BEQ = 5'h10, OP_BNE = 5'h11, OP_CALL = 5'h12.
- It also holds a packed struct ex_reg_t for the ID/EX register contents.
- One sub-module, ras_stack: parameter DEPTH; inputs push, pop, push_data; outputs top, empty. Internal wrap pointer and saturating count.

Test Plan:
- Reset then idle: all outputs 0 and EX_VALID = 0 for 5 cycles. Assert rst mid-branch: BRANCH is 0 on the next cycle.
- BEQ at IF_PC = 0x10, imm = 0xFFFC, QT_A = QT_B = 5, A_SEL = 1, B_SEL = 0: one cycle after capture ALU_Z = 1, BRANCH = 1, SE_PC = 0x0D. The next 2 valid slots are squashed (EX_VALID = 0).
- BNE with equal operands: BRANCH = 0, ALU_Z = 1, no squash; the next instruction is captured normally.
- CALL at IF_PC = 0x20 to 0x100, then a return: SE_PC = 0x100, then SE_PC = 0x21.
- 9 calls with RAS_DEPTH = 8, then 8 returns: the targets come back in LIFO order and the oldest return address is lost. A 9th return gives SE_PC = RESET_VECTOR and RAS_ERR = 1, which stays set.
- Return in the shadow of a taken BEQ, with IF_VALID = 0 gaps inserted: the stack is untouched and the counter holds across invalid slots.
